ibex_rvfi_trace_buffer: RTL

On-chip capture buffer for retired-instruction records taken from the core's RVFI bus. It is a parametrised successor to the tracer-equipped top: instead of printing every retirement, it filters retirements by run-time mode, waits for an optional PC trigger, and stores records in a ring of Depth entries. A valid/ready stream drains the ring for the debug/host side. It sits beside ibex_top under `ifdef RVFI` and can coexist with ibex_tracer.

---
 rtl/ibex_trace_pkg.sv | 31 +++
 rtl/ibex_trace_fifo.sv | 81 ++++++++
 rtl/ibex_rvfi_trace_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace capture buffer: record layout, filter modes
// and capture FSM states.
package ibex_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic        trap;
    logic        intr;
  } trace_rec_t;

  localparam int unsigned TraceRecW = $bits(trace_rec_t);

  typedef enum logic [1:0] {
    ALL       = 2'd0,
    TRAP_ONLY = 2'd1,
    PC_WINDOW = 2'd2,
    MEM_ONLY  = 2'd3
  } trace_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

endpackage

// File: rtl/ibex_trace_fifo.sv
// Show-ahead flop-array FIFO; when full and not popped, a push either drops
// the new entry or overwrites the oldest one (Overwrite=1).
module ibex_trace_fifo #(
  parameter int unsigned Depth     = 64,
  parameter int unsigned Width     = 135,
  parameter bit          Overwrite = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o,
  output logic                   dropped_c_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LvlW-1:0]  r_level, w_level_nxt;
  logic             r_full, r_empty;
  logic             w_pop, w_drop, w_write, w_adv_rd;

  assign w_pop    = pop_i && !r_empty;
  assign w_drop   = push_i && r_full && !w_pop;
  assign w_write  = push_i && (!w_drop || Overwrite);
  // An overwrite retires the oldest entry, so the read side advances with it.
  assign w_adv_rd = w_pop || (w_drop && Overwrite);

  always_comb begin
    w_level_nxt = r_level;
    if (w_write && !w_adv_rd) begin
      w_level_nxt = r_level + LvlW'(1);
    end else if (!w_write && w_adv_rd) begin
      w_level_nxt = r_level - LvlW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_write)  r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_adv_rd) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LvlW'(Depth));
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_write && !clear_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  assign data_o      = r_mem[r_rd_ptr];
  assign full_o      = r_full;
  assign empty_o     = r_empty;
  assign level_o     = r_level;
  assign dropped_c_o = w_drop;

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement capture: mode filter, optional PC trigger, capture FSM and
// drop accounting around a ring buffer drained by a valid/ready stream.
module ibex_rvfi_trace_buffer
  import ibex_trace_pkg::*;
#(
  parameter int unsigned Depth      = 64,
  parameter bit          StopOnFull = 1'b1,
  parameter int unsigned DropCntW   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   arm_i,
  input  logic                   stop_i,
  input  logic                   clear_i,
  input  logic [1:0]             mode_i,
  input  logic [31:0]            pc_lo_i,
  input  logic [31:0]            pc_hi_i,
  input  logic                   trig_en_i,
  input  logic [31:0]            trig_pc_i,
  input  logic                   rvfi_valid,
  input  logic                   rvfi_trap,
  input  logic                   rvfi_intr,
  input  logic [31:0]            rvfi_pc_rdata,
  input  logic [31:0]            rvfi_insn,
  input  logic [31:0]            rvfi_rd_wdata,
  input  logic [31:0]            rvfi_mem_addr,
  input  logic [4:0]             rvfi_rd_addr,
  input  logic [3:0]             rvfi_mem_rmask,
  input  logic [3:0]             rvfi_mem_wmask,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [TraceRecW-1:0]   out_rec_o,
  output logic [$clog2(Depth):0] level_o,
  output logic [1:0]             state_o,
  output logic                   overflow_o,
  output logic [DropCntW-1:0]    drop_cnt_o
);

  trace_state_e          r_state, w_state_nxt;
  trace_rec_t            w_rec;
  logic                  w_filt, w_trig_hit, w_push, w_full, w_empty, w_dropped, w_full_stop;
  logic                  r_overflow;
  logic [DropCntW-1:0]   r_drop_cnt;

  assign w_rec = '{pc: rvfi_pc_rdata, insn: rvfi_insn, rd_addr: rvfi_rd_addr,
                   rd_wdata: rvfi_rd_wdata, mem_addr: rvfi_mem_addr,
                   trap: rvfi_trap, intr: rvfi_intr};

  always_comb begin
    w_filt = 1'b0;
    case (trace_mode_e'(mode_i))
      ALL:       w_filt = 1'b1;
      TRAP_ONLY: w_filt = rvfi_trap || rvfi_intr;
      PC_WINDOW: w_filt = (rvfi_pc_rdata >= pc_lo_i) && (rvfi_pc_rdata <= pc_hi_i);
      MEM_ONLY:  w_filt = |(rvfi_mem_rmask | rvfi_mem_wmask);
      default:   w_filt = 1'b0;
    endcase
  end

  // The trigger retirement itself is eligible for capture.
  assign w_trig_hit  = (r_state == ARMED) && trig_en_i && rvfi_valid &&
                       (rvfi_pc_rdata == trig_pc_i);
  assign w_push      = rvfi_valid && w_filt && !clear_i &&
                       ((r_state == CAPTURE) || w_trig_hit);
  assign w_full_stop = StopOnFull && w_push && w_full && !(out_ready_i && !w_empty);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (arm_i) w_state_nxt = ARMED;
      ARMED: begin
        if (stop_i || w_full_stop)           w_state_nxt = DONE;
        else if (!trig_en_i || w_trig_hit)   w_state_nxt = CAPTURE;
      end
      CAPTURE: if (stop_i || w_full_stop) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (clear_i) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (clear_i) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_dropped) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DropCntW'(1);
      end
    end
  end

  ibex_trace_fifo #(
    .Depth     (Depth),
    .Width     (TraceRecW),
    .Overwrite (!StopOnFull)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_i      (w_push),
    .data_i      (w_rec),
    .pop_i       (out_ready_i),
    .data_o      (out_rec_o),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .level_o     (level_o),
    .dropped_c_o (w_dropped)
  );

  assign out_valid_o = !w_empty;
  assign state_o     = r_state;
  assign overflow_o  = r_overflow;
  assign drop_cnt_o  = r_drop_cnt;

endmodule
